// File: rtl/sysid_access_ctrl.sv
// sysid_access_ctrl
// Arbitrates a single zero-wait sysid slave between a host Avalon-MM read
// port and an internal ID/timestamp self-check. A check reads address 0 then
// address 1 and compares both words against the expected constants. Host
// reads are stalled with waitrequest whenever a check is running or pending.
module sysid_access_ctrl #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1460600513,
  parameter bit          AUTO_CHECK         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        check_start,
  input  logic        host_read,
  input  logic        host_address,
  output logic        host_waitrequest,
  output logic [31:0] host_readdata,
  output logic        host_readdatavalid,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  output logic        check_busy,
  output logic        check_done,
  output logic        check_pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [7:0]  fail_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHK_ID  = 3'd1,
    CHK_TS  = 3'd2,
    CHK_END = 3'd3,
    HOST    = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic start_pending;
  logic start_check;   // IDLE -> CHK_ID this cycle
  logic accept_read;   // IDLE -> HOST this cycle
  logic match;

  assign match = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);

  // State register; a synchronous reset drops any operation in flight.
  always_ff @(posedge clock) begin
    // NOTE: state and all registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode, host acceptance and busy flag; a pending or new check
  // always wins over a host read arriving in the same IDLE cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_d     = state_q;
    start_check = 1'b0;
    accept_read = 1'b0;
    check_busy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_pending || check_start) begin
          state_d     = CHK_ID;
          start_check = 1'b1;
        end else if (host_read) begin
          state_d     = HOST;
          accept_read = 1'b1;
        end
      end
      HOST: state_d = IDLE;
      CHK_ID: begin
        check_busy = 1'b1;
        state_d    = CHK_TS;
      end
      CHK_TS: begin
        check_busy = 1'b1;
        state_d    = CHK_END;
      end
      CHK_END: begin
        check_busy = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A held host read simply stays stalled until an IDLE cycle accepts it.
  assign host_waitrequest = host_read && !accept_read;

  // Datapath: slave address, captured words, host data, strobes and result.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      start_pending      <= AUTO_CHECK;
      sid_address        <= 1'b0;
      host_readdata      <= 32'd0;
      host_readdatavalid <= 1'b0;
      check_done         <= 1'b0;
      check_pass         <= 1'b0;
      id_value           <= 32'd0;
      ts_value           <= 32'd0;
      fail_count         <= 8'd0;
    end else begin
      host_readdatavalid <= 1'b0;
      check_done         <= 1'b0;

      // Any number of requests while busy collapse into one further check.
      if (start_check)      start_pending <= 1'b0;
      else if (check_start) start_pending <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (start_check)      sid_address <= 1'b0;
          else if (accept_read) sid_address <= host_address;
        end
        HOST: begin
          host_readdata      <= sid_readdata;
          host_readdatavalid <= 1'b1;
        end
        CHK_ID: begin
          id_value    <= sid_readdata;
          sid_address <= 1'b1;
        end
        CHK_TS: begin
          ts_value <= sid_readdata;
        end
        CHK_END: begin
          check_pass <= match;
          check_done <= 1'b1;
          if (!match && (fail_count != 8'hFF)) fail_count <= fail_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_access_ctrl.sv
// Self-checking bench for sysid_access_ctrl: directed scenarios followed by a
// randomized run, all compared every cycle against a transaction-level model.
module tb_sysid_access_ctrl;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1460600513;
  localparam bit          AUTO   = 1'b1;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        check_start;
  logic        host_read;
  logic        host_address;
  logic        host_waitrequest;
  logic [31:0] host_readdata;
  logic        host_readdatavalid;
  logic        sid_address;
  logic [31:0] sid_readdata;
  logic        check_busy;
  logic        check_done;
  logic        check_pass;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic [7:0]  fail_count;

  // Words presented by the sysid slave model.
  logic [31:0] id_word;
  logic [31:0] ts_word;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  always #5 clock = ~clock;

  assign sid_readdata = sid_address ? ts_word : id_word;

  sysid_access_ctrl #(
    .EXPECTED_ID       (EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .AUTO_CHECK        (AUTO)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .check_start       (check_start),
    .host_read         (host_read),
    .host_address      (host_address),
    .host_waitrequest  (host_waitrequest),
    .host_readdata     (host_readdata),
    .host_readdatavalid(host_readdatavalid),
    .sid_address       (sid_address),
    .sid_readdata      (sid_readdata),
    .check_busy        (check_busy),
    .check_done        (check_done),
    .check_pass        (check_pass),
    .id_value          (id_value),
    .ts_value          (ts_value),
    .fail_count        (fail_count)
  );

  // Reference model: a check is an operation three cycles long, a host read
  // one cycle long; results appear the cycle after the operation ends.
  int          m_chk_cycle;   // 0 = no check running, else cycle 1..3 of it
  bit          m_host;        // host read in progress
  bit          m_haddr;
  bit          m_pending;
  bit          m_done;
  bit          m_valid;
  logic [31:0] m_rdata;
  bit          m_pass;
  logic [31:0] m_id;
  logic [31:0] m_ts;
  int          m_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit cs, input bit hr, input bit ha, input bit rn);
    if (!rn) begin
      m_chk_cycle = 0; m_host = 0; m_haddr = 0; m_pending = AUTO;
      m_done = 0; m_valid = 0; m_rdata = 0; m_pass = 0;
      m_id = 0; m_ts = 0; m_fail = 0;
    end else begin
      m_done  = 0;
      m_valid = 0;
      if (m_chk_cycle == 0 && !m_host) begin
        if (m_pending || cs) begin
          m_chk_cycle = 1;
          m_pending   = 0;
        end else if (hr) begin
          m_host  = 1;
          m_haddr = ha;
        end
      end else begin
        if (cs) m_pending = 1;
        if (m_host) begin
          m_rdata = m_haddr ? ts_word : id_word;
          m_valid = 1;
          m_host  = 0;
        end else if (m_chk_cycle == 1) begin
          m_id = id_word;
          m_chk_cycle = 2;
        end else if (m_chk_cycle == 2) begin
          m_ts = ts_word;
          m_chk_cycle = 3;
        end else begin
          m_pass = (m_id == EXP_ID) && (m_ts == EXP_TS);
          if (!m_pass && m_fail < 255) m_fail++;
          m_done = 1;
          m_chk_cycle = 0;
        end
      end
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare all outputs,
  // then advance the model across the rising edge.
  task automatic cycle(input bit cs, input bit hr, input bit ha, input bit rn, output bit acc);
    bit idle;
    bit exp_wait;
    check_start  = cs;
    host_read    = hr;
    host_address = ha;
    reset_n      = rn;
    #1;
    idle     = (m_chk_cycle == 0) && !m_host;
    exp_wait = hr && !(idle && !m_pending && !cs);
    acc      = hr && !exp_wait;
    check("waitrequest", 32'(host_waitrequest), 32'(exp_wait));
    check("busy", 32'(check_busy), 32'(m_chk_cycle != 0));
    check("done", 32'(check_done), 32'(m_done));
    check("readdatavalid", 32'(host_readdatavalid), 32'(m_valid));
    check("readdata", host_readdata, m_rdata);
    check("pass", 32'(check_pass), 32'(m_pass));
    check("id_value", id_value, m_id);
    check("ts_value", ts_value, m_ts);
    check("fail_count", 32'(fail_count), 32'(m_fail));
    if (check_done === 1'b1) done_seen++;
    @(posedge clock);
    model_step(cs, hr, ha, rn);
    @(negedge clock);
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, acc);
  endtask

  // Holds a host read until the model says it is accepted (bounded wait).
  task automatic host_access(input bit ha, input bit cs_first);
    bit acc;
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(cs_first && (i == 0), 1, ha, 1, acc);
      got = acc;
    end
    check("host_accept_timeout", 32'(got), 32'd1);
    idle_cycles(3);
  endtask

  initial begin
    bit acc;
    bit hr_hold;
    bit hr_addr;
    bit cs;
    bit rn;
    int start_done;

    id_word = EXP_ID;
    ts_word = EXP_TS;
    check_start = 0; host_read = 0; host_address = 0; reset_n = 0;
    model_step(0, 0, 0, 0);
    @(negedge clock);

    // Reset, then the automatic check with a matching slave.
    cycle(0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, acc);
    check("sid_address_reset", 32'(sid_address), 32'd0);
    start_done = done_seen;
    idle_cycles(7);
    check("auto_check_done_count", 32'(done_seen - start_done), 32'd1);
    check("auto_check_pass", 32'(check_pass), 32'd1);

    // Host reads of both words while idle.
    host_access(1, 0);
    check("host_ts_word", host_readdata, EXP_TS);
    host_access(0, 0);

    // Mismatching ID word.
    id_word = 32'hDEADBEEF;
    cycle(1, 0, 0, 1, acc);
    idle_cycles(5);
    check("mismatch_id", id_value, 32'hDEADBEEF);
    check("mismatch_count", 32'(fail_count), 32'd1);
    id_word = EXP_ID;

    // Check request and host read in the same cycle.
    ts_word = 32'h0BAD_F00D;
    host_access(1, 1);
    check("collision_data", host_readdata, 32'h0BAD_F00D);
    ts_word = EXP_TS;

    // Extra requests while a check runs collapse into one more check.
    start_done = done_seen;
    cycle(1, 0, 0, 1, acc);
    cycle(1, 0, 0, 1, acc);
    cycle(1, 0, 0, 1, acc);
    idle_cycles(10);
    check("rerequest_done_count", 32'(done_seen - start_done), 32'd2);

    // Reset while the check sits in its timestamp cycle; auto check reruns.
    start_done = done_seen;
    cycle(1, 0, 0, 1, acc);
    cycle(0, 0, 0, 1, acc);
    cycle(0, 0, 0, 0, acc);
    check("abort_no_done", 32'(check_done), 32'd0);
    idle_cycles(7);
    check("abort_rerun_done_count", 32'(done_seen - start_done), 32'd1);

    // Saturate the failure counter.
    id_word = 32'hDEADBEEF;
    for (int i = 0; i < 256; i++) begin
      cycle(1, 0, 0, 1, acc);
      idle_cycles(3);
    end
    idle_cycles(2);
    check("fail_count_saturated", 32'(fail_count), 32'd255);

    // Randomized traffic: checks, held host reads, word changes, rare resets.
    hr_hold = 0;
    hr_addr = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) id_word = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
      if ($urandom_range(0, 15) == 0) ts_word = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
      if (!hr_hold && $urandom_range(0, 3) == 0) begin
        hr_hold = 1;
        hr_addr = 1'($urandom_range(0, 1));
      end
      cs = ($urandom_range(0, 9) == 0);
      rn = ($urandom_range(0, 199) != 0);
      cycle(cs, hr_hold, hr_addr, rn, acc);
      if (acc || !rn) hr_hold = 0;
    end
    idle_cycles(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
